fu_issue_buffer: RTL and testbench

- Request buffer and in-flight tracker directly upstream of a generic functional unit (FU) port.
- Accepts operator/operand requests tagged with a transaction ID from the issue stage and queues them.
- Dispatches them to the FU with a valid/ready handshake and caps the number of outstanding operations.
- Re-associates each in-order FU result with its transaction ID and presents it to writeback.

---
 rtl/fu_issue_pkg.sv | 26 ++
 rtl/fu_issue_fifo.sv | 69 ++++++
 rtl/fu_issue_buffer.sv | 166 ++++++++++++++++
 tb/tb_fu_issue_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_issue_pkg.sv
// Shared types and default sizes for the FU issue buffer.
package fu_issue_pkg;

  localparam int unsigned FU_OPERATOR_SIZE   = 8;
  localparam int unsigned FU_OPERAND_SIZE    = 64;
  localparam int unsigned FU_TRANS_ID_BITS   = 3;
  localparam int unsigned FU_DEPTH           = 4;
  localparam int unsigned FU_MAX_OUTSTANDING = 2;

  // Request as it arrives from the issue stage (default sizes).
  typedef struct packed {
    logic [FU_OPERATOR_SIZE-1:0] operator;
    logic [FU_OPERAND_SIZE-1:0]  operand_a;
    logic [FU_OPERAND_SIZE-1:0]  operand_b;
    logic [FU_OPERAND_SIZE-1:0]  operand_c;
    logic [FU_TRANS_ID_BITS-1:0] trans_id;
  } req_t;

  // Retired result as presented to writeback (default sizes).
  typedef struct packed {
    logic [FU_TRANS_ID_BITS-1:0] trans_id;
    logic [FU_OPERAND_SIZE-1:0]  result;
    logic                        comparison;
  } wb_t;

endpackage

// File: rtl/fu_issue_fifo.sv
// Generic registered FIFO: head visible on data_o, no write-to-read bypass,
// synchronous flush empties it in one edge.
module fu_issue_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Explicit wrap so non-power-of-two pointer ranges (DEPTH=1) behave too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rptr];

  // Storage: write at the tail; cleared on reset so the head never shows X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push && !flush_i) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fu_issue_buffer.sv
// Request queue, outstanding-op limiter and in-order tag re-association
// between the issue stage and a functional unit.
module fu_issue_buffer
  import fu_issue_pkg::*;
#(
  parameter int unsigned OPERATOR_SIZE   = FU_OPERATOR_SIZE,
  parameter int unsigned OPERAND_SIZE    = FU_OPERAND_SIZE,
  parameter int unsigned TRANS_ID_BITS   = FU_TRANS_ID_BITS,
  parameter int unsigned DEPTH           = FU_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = FU_MAX_OUTSTANDING
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [OPERATOR_SIZE-1:0] req_operator_i,
  input  logic [OPERAND_SIZE-1:0]  req_operand_a_i,
  input  logic [OPERAND_SIZE-1:0]  req_operand_b_i,
  input  logic [OPERAND_SIZE-1:0]  req_operand_c_i,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  output logic                     fu_valid_o,
  input  logic                     fu_ready_i,
  output logic [OPERATOR_SIZE-1:0] fu_operator_o,
  output logic [OPERAND_SIZE-1:0]  fu_operand_a_o,
  output logic [OPERAND_SIZE-1:0]  fu_operand_b_o,
  output logic [OPERAND_SIZE-1:0]  fu_operand_c_o,
  input  logic                     fu_result_valid_i,
  input  logic [OPERAND_SIZE-1:0]  fu_result_i,
  input  logic                     fu_comparison_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [OPERAND_SIZE-1:0]  wb_result_o,
  output logic                     wb_comparison_o,
  output logic                     error_o
);

  localparam int unsigned REQ_W = OPERATOR_SIZE + 3 * OPERAND_SIZE + TRANS_ID_BITS;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  // Drain is computed as drain + outstanding, so give it one spare bit.
  localparam int unsigned DRN_W = CNT_W + 1;

  logic [REQ_W-1:0]         w_req_in;
  logic [REQ_W-1:0]         w_req_head;
  logic                     w_req_full;
  logic                     w_req_empty;
  logic                     w_req_push;
  logic [TRANS_ID_BITS-1:0] w_head_id;
  logic [TRANS_ID_BITS-1:0] w_id_head;
  logic                     w_id_full;
  logic                     w_id_empty;
  logic                     w_dispatch;
  logic                     w_retire;
  logic                     w_discard;
  logic                     w_spurious;
  logic [DRN_W-1:0]         w_pending;
  logic [DRN_W-1:0]         w_drain_flush;

  logic [CNT_W-1:0]         r_outstanding;
  logic [DRN_W-1:0]         r_drain;
  logic                     r_wb_valid;
  logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
  logic [OPERAND_SIZE-1:0]  r_wb_result;
  logic                     r_wb_comparison;
  logic                     r_error;

  assign w_req_in = {req_operator_i, req_operand_a_i, req_operand_b_i,
                     req_operand_c_i, req_trans_id_i};
  assign {fu_operator_o, fu_operand_a_o, fu_operand_b_o, fu_operand_c_o,
          w_head_id} = w_req_head;

  // Ready comes only from registered occupancy; flush refuses new work.
  assign req_ready_o = !w_req_full && !flush_i;
  assign w_req_push  = req_valid_i && req_ready_o;

  // Dispatch waits for stale results to drain so tags cannot alias.
  assign fu_valid_o = !w_req_empty && (r_outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                      !w_id_full && !flush_i && (r_drain == '0);
  assign w_dispatch = fu_valid_o && fu_ready_i;

  assign w_retire   = fu_result_valid_i && !w_id_empty && (r_drain == '0) && !flush_i;
  assign w_discard  = fu_result_valid_i && (r_drain != '0);
  assign w_spurious = fu_result_valid_i && (r_outstanding == '0) && (r_drain == '0);

  // On flush every in-flight op becomes a result to discard; one arriving
  // in the flush cycle itself is already accounted for.
  assign w_pending     = r_drain + DRN_W'(r_outstanding);
  assign w_drain_flush = w_pending -
                         DRN_W'(fu_result_valid_i && (w_pending != '0));

  fu_issue_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_req_push),
    .pop_i   (w_dispatch),
    .data_i  (w_req_in),
    .data_o  (w_req_head),
    .full_o  (w_req_full),
    .empty_o (w_req_empty)
  );

  fu_issue_fifo #(
    .WIDTH (TRANS_ID_BITS),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_dispatch),
    .pop_i   (w_retire),
    .data_i  (w_head_id),
    .data_o  (w_id_head),
    .full_o  (w_id_full),
    .empty_o (w_id_empty)
  );

  // Outstanding/drain counters and the sticky spurious-result flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_drain       <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_spurious) r_error <= 1'b1;
      if (flush_i) begin
        r_outstanding <= '0;
        r_drain       <= w_drain_flush;
      end else begin
        if (w_discard) r_drain <= r_drain - 1'b1;
        unique case ({w_dispatch, w_retire})
          2'b10:   r_outstanding <= r_outstanding + 1'b1;
          2'b01:   r_outstanding <= r_outstanding - 1'b1;
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

  // Writeback register: one-cycle pulse per retire, data held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid      <= 1'b0;
      r_wb_trans_id   <= '0;
      r_wb_result     <= '0;
      r_wb_comparison <= 1'b0;
    end else begin
      r_wb_valid <= w_retire;
      if (w_retire) begin
        r_wb_trans_id   <= w_id_head;
        r_wb_result     <= fu_result_i;
        r_wb_comparison <= fu_comparison_i;
      end
    end
  end

  assign wb_valid_o      = r_wb_valid;
  assign wb_trans_id_o   = r_wb_trans_id;
  assign wb_result_o     = r_wb_result;
  assign wb_comparison_o = r_wb_comparison;
  assign error_o         = r_error;

endmodule

// File: tb/tb_fu_issue_buffer.sv
// Scoreboard bench for fu_issue_buffer: a reference model of the queue,
// in-flight tags and drain count runs on the falling edge.
module tb_fu_issue_buffer;
  import fu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_operator = '0;
  logic [63:0] req_a = '0, req_b = '0, req_c = '0;
  logic [2:0]  req_id = '0;
  logic        fu_valid_o;
  logic        fu_ready = 1'b0;
  logic [7:0]  fu_operator_o;
  logic [63:0] fu_a_o, fu_b_o, fu_c_o;
  logic        fu_res_valid = 1'b0;
  logic [63:0] fu_res = '0;
  logic        fu_cmp = 1'b0;
  logic        wb_valid_o;
  logic [2:0]  wb_id_o;
  logic [63:0] wb_result_o;
  logic        wb_cmp_o;
  logic        error_o;

  int n_cmp = 0;
  int n_bad = 0;

  req_t       m_req[$];
  logic [2:0] m_inflight[$];
  wb_t        m_wb[$];
  int         m_drain = 0;
  logic       m_err = 1'b0;

  fu_issue_buffer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready_o),
    .req_operator_i    (req_operator),
    .req_operand_a_i   (req_a),
    .req_operand_b_i   (req_b),
    .req_operand_c_i   (req_c),
    .req_trans_id_i    (req_id),
    .fu_valid_o        (fu_valid_o),
    .fu_ready_i        (fu_ready),
    .fu_operator_o     (fu_operator_o),
    .fu_operand_a_o    (fu_a_o),
    .fu_operand_b_o    (fu_b_o),
    .fu_operand_c_o    (fu_c_o),
    .fu_result_valid_i (fu_res_valid),
    .fu_result_i       (fu_res),
    .fu_comparison_i   (fu_cmp),
    .wb_valid_o        (wb_valid_o),
    .wb_trans_id_o     (wb_id_o),
    .wb_result_o       (wb_result_o),
    .wb_comparison_o   (wb_cmp_o),
    .error_o           (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: checks use pre-edge state, then the model steps.
  always @(negedge clk) begin
    req_t h;
    wb_t  w;
    bit   exp_fv, exp_rr;
    if (!rst_n) begin
      m_req.delete();
      m_inflight.delete();
      m_wb.delete();
      m_drain = 0;
      m_err   = 1'b0;
    end else begin
      exp_rr = (m_req.size() < 4) && !flush;
      exp_fv = (m_req.size() != 0) && (m_inflight.size() < 2) && !flush && (m_drain == 0);
      chk("req_ready", req_ready_o, exp_rr);
      chk("fu_valid", fu_valid_o, exp_fv);
      if (fu_valid_o && m_req.size() != 0) begin
        h = m_req[0];
        chk("fu_operator", fu_operator_o, h.operator);
        chk("fu_operand_a", fu_a_o, h.operand_a);
        chk("fu_operand_b", fu_b_o, h.operand_b);
        chk("fu_operand_c", fu_c_o, h.operand_c);
      end
      chk("wb_valid", wb_valid_o, m_wb.size() != 0);
      if (wb_valid_o && m_wb.size() != 0) begin
        w = m_wb.pop_front();
        chk("wb_trans_id", wb_id_o, w.trans_id);
        chk("wb_result", wb_result_o, w.result);
        chk("wb_comparison", wb_cmp_o, w.comparison);
        $display("WB   id=%0d result=0x%0h cmp=%0b", wb_id_o, wb_result_o, wb_cmp_o);
      end
      m_wb.delete();
      chk("error", error_o, m_err);

      if (flush) begin
        if (fu_res_valid) begin
          if (m_drain + m_inflight.size() > 0) m_drain = m_drain + m_inflight.size() - 1;
          else m_err = 1'b1;
        end else begin
          m_drain = m_drain + m_inflight.size();
        end
        m_inflight.delete();
        m_req.delete();
      end else begin
        if (fu_res_valid) begin
          if (m_drain > 0) m_drain--;
          else if (m_inflight.size() > 0) begin
            w.trans_id   = m_inflight.pop_front();
            w.result     = fu_res;
            w.comparison = fu_cmp;
            m_wb.push_back(w);
          end else m_err = 1'b1;
        end
        if (exp_fv && fu_ready) begin
          h = m_req.pop_front();
          m_inflight.push_back(h.trans_id);
          $display("DISP id=%0d op=0x%0h", h.trans_id, h.operator);
        end
        if (req_valid && exp_rr) begin
          h.operator  = req_operator;
          h.operand_a = req_a;
          h.operand_b = req_b;
          h.operand_c = req_c;
          h.trans_id  = req_id;
          m_req.push_back(h);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc = 0;
    int budget = 50;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = req_ready_o;
      tick();
      budget--;
    end
    chk("accept_timeout", acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] id, input logic [7:0] op,
                      input logic [63:0] a, input logic [63:0] b);
    req_valid    = 1'b1;
    req_id       = id;
    req_operator = op;
    req_a        = a;
    req_b        = b;
    req_c        = {$urandom, $urandom};
    wait_accept();
  endtask

  task automatic result(input logic [63:0] val, input logic cmp);
    fu_res_valid = 1'b1;
    fu_res       = val;
    fu_cmp       = cmp;
    tick();
    fu_res_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_fu_valid", fu_valid_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_result", wb_result_o, 0);
    chk("rst_error", error_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single op
    fu_ready = 1'b1;
    send(3'd2, 8'h05, 64'd3, 64'd4);
    tick();
    tick();
    result(64'd7, 1'b0);
    repeat (3) tick();

    // 2: full / backpressure
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'(i), 8'(8'h10 + i), {$urandom, $urandom}, 64'(i));
    @(negedge clk);
    chk("full_ready", req_ready_o, 0);
    req_valid = 1'b1;
    req_id    = 3'd4;
    req_operator = 8'h14;
    tick();
    tick();
    fu_ready = 1'b1;
    wait_accept();
    for (int k = 0; k < 5; k++) begin
      result(64'(16 * k + 1), k[0]);
      tick();
    end
    repeat (3) tick();

    // 3: outstanding cap
    send(3'd1, 8'h21, 64'd1, 64'd1);
    send(3'd2, 8'h22, 64'd2, 64'd2);
    send(3'd3, 8'h23, 64'd3, 64'd3);
    repeat (3) tick();
    @(negedge clk);
    chk("cap_block", fu_valid_o, 0);
    tick();
    result(64'h11, 1'b1);
    @(negedge clk);
    chk("cap_release", fu_valid_o, 1);
    tick();
    tick();
    result(64'h12, 1'b0);
    tick();
    result(64'h13, 1'b1);
    repeat (3) tick();

    // 4: ordering, back-to-back results
    send(3'd5, 8'h31, 64'h5, 64'h50);
    send(3'd6, 8'h32, 64'h6, 64'h60);
    repeat (2) tick();
    result(64'hAA, 1'b0);
    result(64'hBB, 1'b1);
    repeat (3) tick();

    // 5: flush with work in flight and queued
    for (int i = 0; i < 4; i++) send(3'(i), 8'(8'h40 + i), {$urandom, $urandom}, 64'(i));
    repeat (2) tick();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_id    = 3'd7;
    @(negedge clk);
    chk("flush_fu_valid", fu_valid_o, 0);
    chk("flush_req_ready", req_ready_o, 0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty", fu_valid_o, 0);
    tick();
    result(64'h33, 1'b0);
    tick();
    result(64'h44, 1'b0);
    repeat (2) tick();
    send(3'd1, 8'h51, 64'h1, 64'h2);
    repeat (2) tick();
    result(64'h55, 1'b1);
    repeat (3) tick();

    // 6: spurious result, then asynchronous reset mid-traffic
    result(64'h99, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    chk("spurious_err", error_o, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("sticky_err", error_o, 1);
    tick();
    fu_ready = 1'b0;
    send(3'd3, 8'h61, 64'h3, 64'h3);
    send(3'd4, 8'h62, 64'h4, 64'h4);
    fu_ready = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready_o, 1);
    chk("arst_fu_valid", fu_valid_o, 0);
    chk("arst_wb_valid", wb_valid_o, 0);
    chk("arst_wb_id", wb_id_o, 0);
    chk("arst_wb_result", wb_result_o, 0);
    chk("arst_error", error_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    result(64'h77, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    chk("post_reset_spurious", error_o, 1);
    repeat (2) tick();
    chk("end_queue_empty", m_req.size(), 0);
    chk("end_inflight_empty", m_inflight.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
